// File: rtl/event_encoder_8to3_pkg.sv
// Shared types and width helpers for the event encoder.
// FSM state encoding plus the clog2-derived index width.
package event_encoder_8to3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int N_DEF = 8;

  function automatic int enc_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int W_DEF = enc_width(N_DEF);

endpackage

// File: rtl/event_encoder_8to3_if.sv
// Valid/ready index port of the event encoder.
// master drives the index, slave returns ready.
interface event_encoder_8to3_if #(
  parameter int W = 3
) ();

  logic [W-1:0] y;
  logic         y_valid;
  logic         y_ready;

  modport master (
    output y,
    output y_valid,
    input  y_ready
  );

  modport slave (
    input  y,
    input  y_valid,
    output y_ready
  );

endinterface

// File: rtl/event_encoder_8to3_prio_enc.sv
// Combinational priority encoder: vector in, index + any-set out.
// LSB_FIRST selects whether the lowest or highest set line wins.
module event_encoder_8to3_prio_enc
  import event_encoder_8to3_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = enc_width(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    if (LSB_FIRST) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end
  end

  assign any = |vec;

endmodule

// File: rtl/event_encoder_8to3.sv
// Sticky event collector emitting one line index per valid/ready transfer.
// Pending lines clear only when their index is accepted.
module event_encoder_8to3
  import event_encoder_8to3_pkg::*;
#(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b0,
  localparam int W        = enc_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] d,
  input  logic         clr_ovr,
  output logic [N-1:0] pending,
  output logic         overrun,
  event_encoder_8to3_if.master yo
);

  state_t       state_q, state_d;
  logic [W-1:0] y_q, y_d;
  logic         yv_q, yv_d;
  logic [N-1:0] pend_q;
  logic [N-1:0] clr_mask;
  logic [N-1:0] rem;
  logic         ovr_q;
  logic         ovr_set;
  logic         xfer;
  logic [W-1:0] idx_p, idx_r;
  logic         any_p, any_r;

  assign xfer = yv_q & yo.y_ready;

  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (xfer && (y_q == W'(i))) clr_mask[i] = 1'b1;
    end
  end

  assign rem     = pend_q & ~clr_mask;
  assign ovr_set = |(d & rem);

  event_encoder_8to3_prio_enc #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio_pend (
    .vec (pend_q),
    .idx (idx_p),
    .any (any_p)
  );

  event_encoder_8to3_prio_enc #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_prio_rem (
    .vec (rem),
    .idx (idx_r),
    .any (any_r)
  );

  // HOLD ignores newer events until the held index is accepted
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    yv_d    = yv_q;
    unique case (state_q)
      IDLE: begin
        yv_d = 1'b0;
        if (any_p) begin
          y_d     = idx_p;
          yv_d    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (xfer) begin
          if (any_r) begin
            y_d  = idx_r;
            yv_d = 1'b1;
          end else begin
            yv_d    = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        yv_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      yv_q    <= 1'b0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      pend_q  <= rem | d;
      ovr_q   <= ovr_set | (ovr_q & ~clr_ovr);
    end
  end

  assign yo.y       = y_q;
  assign yo.y_valid = yv_q;
  assign pending    = pend_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Directed self-checking bench for event_encoder_8to3.
// Runs an MSB-first and an LSB-first instance side by side.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] d;
  logic       clr_ovr;
  logic [7:0] pending, pending2;
  logic       overrun, overrun2;
  int         n_cmp = 0;
  int         n_bad = 0;

  event_encoder_8to3_if #(.W(3)) y_if ();
  event_encoder_8to3_if #(.W(3)) y_if2 ();

  event_encoder_8to3 #(.N(8), .LSB_FIRST(1'b0)) dut (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .clr_ovr (clr_ovr),
    .pending (pending),
    .overrun (overrun),
    .yo      (y_if.master)
  );

  event_encoder_8to3 #(.N(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk     (clk),
    .rst     (rst),
    .d       (d),
    .clr_ovr (clr_ovr),
    .pending (pending2),
    .overrun (overrun2),
    .yo      (y_if2.master)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; d = '0; clr_ovr = 1'b0;
    y_if.y_ready = 1'b0; y_if2.y_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (y_if.y_valid !== 1'b0 || pending !== 8'h00 || overrun !== 1'b0 || y_if.y !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%b p=%h o=%b y=%0d want 0 00 0 0",
               y_if.y_valid, pending, overrun, y_if.y);
    end
    d = 8'h20;
    tick();
    d = 8'h00;
    tick();
    n_cmp++;
    if (y_if.y !== 3'd5 || y_if.y_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_hold5: got y=%0d v=%b want 5 1", y_if.y, y_if.y_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (y_if.y_valid !== 1'b0 || pending !== 8'h00 || overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b p=%h o=%b want 0 00 0",
               y_if.y_valid, pending, overrun);
    end
    tick();
    rst = 1'b0;
    tick(); tick();
    n_cmp++;
    if (y_if.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_no_replay: got v=%b want 0", y_if.y_valid);
    end
  endtask

  task automatic test_single();
    y_if.y_ready = 1'b1;
    d = 8'h04;
    tick();
    d = 8'h00;
    n_cmp++;
    if (pending !== 8'h04 || y_if.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_pend: got p=%h v=%b want 04 0", pending, y_if.y_valid);
    end
    tick();
    n_cmp++;
    if (y_if.y !== 3'd2 || y_if.y_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL single_emit: got y=%0d v=%b want 2 1", y_if.y, y_if.y_valid);
    end
    tick();
    n_cmp++;
    if (y_if.y_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL single_done: got v=%b p=%h want 0 00", y_if.y_valid, pending);
    end
  endtask

  task automatic test_burst();
    logic [2:0] exp_m [3];
    logic [2:0] exp_l [3];
    exp_m[0] = 3'd7; exp_m[1] = 3'd2; exp_m[2] = 3'd0;
    exp_l[0] = 3'd0; exp_l[1] = 3'd2; exp_l[2] = 3'd7;
    y_if.y_ready = 1'b1;
    y_if2.y_ready = 1'b1;
    d = 8'h85;
    tick();
    d = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (y_if.y !== exp_m[i] || y_if.y_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL burst_msb[%0d]: got y=%0d v=%b want %0d 1",
                 i, y_if.y, y_if.y_valid, exp_m[i]);
      end
      n_cmp++;
      if (y_if2.y !== exp_l[i] || y_if2.y_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL burst_lsb[%0d]: got y=%0d v=%b want %0d 1",
                 i, y_if2.y, y_if2.y_valid, exp_l[i]);
      end
    end
    tick();
    n_cmp++;
    if (y_if.y_valid !== 1'b0 || y_if2.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL burst_end: got v=%b/%b want 0/0", y_if.y_valid, y_if2.y_valid);
    end
  endtask

  task automatic test_backpressure();
    y_if.y_ready = 1'b0;
    d = 8'h04;
    tick();
    d = 8'h00;
    tick();
    d = 8'h80;
    tick();
    d = 8'h00;
    n_cmp++;
    if (y_if.y !== 3'd2 || y_if.y_valid !== 1'b1 || pending !== 8'h84) begin
      n_bad++;
      $display("FAIL bp_hold: got y=%0d v=%b p=%h want 2 1 84",
               y_if.y, y_if.y_valid, pending);
    end
    tick();
    n_cmp++;
    if (y_if.y !== 3'd2) begin
      n_bad++;
      $display("FAIL bp_stable: got y=%0d want 2", y_if.y);
    end
    y_if.y_ready = 1'b1;
    tick();
    n_cmp++;
    if (y_if.y !== 3'd7 || y_if.y_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_next: got y=%0d v=%b want 7 1", y_if.y, y_if.y_valid);
    end
    tick();
    n_cmp++;
    if (y_if.y_valid !== 1'b0 || pending !== 8'h00) begin
      n_bad++;
      $display("FAIL bp_drain: got v=%b p=%h want 0 00", y_if.y_valid, pending);
    end
  endtask

  task automatic test_overrun();
    y_if.y_ready = 1'b0;
    d = 8'h01;
    tick();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_first: got %b want 0", overrun);
    end
    tick();
    d = 8'h00;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_set: got %b want 1", overrun);
    end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_clear: got %b want 0", overrun);
    end
    y_if.y_ready = 1'b1;
    d = 8'h01;
    tick();
    d = 8'h00;
    n_cmp++;
    if (overrun !== 1'b0 || pending !== 8'h01 || y_if.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_repend: got o=%b p=%h v=%b want 0 01 0",
               overrun, pending, y_if.y_valid);
    end
    tick();
    n_cmp++;
    if (y_if.y !== 3'd0 || y_if.y_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_reemit: got y=%0d v=%b want 0 1", y_if.y, y_if.y_valid);
    end
    tick();
    y_if.y_ready = 1'b0;
    d = 8'h01;
    tick();
    clr_ovr = 1'b1;
    tick();
    d = 8'h00;
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL ovr_set_wins: got %b want 1", overrun);
    end
    tick();
    clr_ovr = 1'b0;
    y_if.y_ready = 1'b1;
    tick(); tick();
    n_cmp++;
    if (overrun !== 1'b0 || pending !== 8'h00 || y_if.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ovr_drain: got o=%b p=%h v=%b want 0 00 0",
               overrun, pending, y_if.y_valid);
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] dec;
    y_if.y_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      dec = 8'h01 << c;
      d = dec;
      tick();
      d = 8'h00;
      tick();
      n_cmp++;
      if (y_if.y !== 3'(c) || y_if.y_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL round_trip[%0d]: got y=%0d v=%b want %0d 1",
                 c, y_if.y, y_if.y_valid, c);
      end
      tick();
    end
    n_cmp++;
    if (overrun !== 1'b0 || y_if.y_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL round_trip_end: got o=%b v=%b want 0 0", overrun, y_if.y_valid);
    end
  endtask

  task automatic test_idle();
    y_if.y_ready = 1'b1;
    d = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (y_if.y_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle[%0d]: got v=%b want 0", i, y_if.y_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_overrun();
    test_round_trip();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
